// File: rtl/alu_issue.sv
// Operand-issue stage in front of a 1-cycle ALU: register-file read with bypass
// from the ALU result, and a one-bubble interlock on back-to-back dependencies.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_imm,
  input  logic            flush,
  output logic [4:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] opd1,
  output logic [XLEN-1:0] opd2,
  input  logic [XLEN-1:0] alu_rslt,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  logic            r_e_valid;
  logic [4:0]      r_e_rd;
  logic            r_w_valid;
  logic [4:0]      r_w_rd;
  logic [XLEN-1:0] r_rf [32];

  logic            w_rs2_used;
  logic            w_hazard;
  logic            w_accept;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  assign w_rs2_used = in_opcode[3];

  // Only the instruction sitting in E can still be ahead of its result; W is covered by bypass.
  assign w_hazard = r_e_valid && (r_e_rd != 5'd0) &&
                    ((in_rs1 == r_e_rd) || (w_rs2_used && (in_rs2 == r_e_rd)));

  assign in_ready = rst && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    if (in_rs1 == 5'd0) begin
      w_rs1_val = '0;
    end else if (r_w_valid && (r_w_rd == in_rs1)) begin
      w_rs1_val = alu_rslt;
    end else begin
      w_rs1_val = r_rf[in_rs1];
    end
  end

  always_comb begin
    if (in_rs2 == 5'd0) begin
      w_rs2_val = '0;
    end else if (r_w_valid && (r_w_rd == in_rs2)) begin
      w_rs2_val = alu_rslt;
    end else begin
      w_rs2_val = r_rf[in_rs2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e_valid <= 1'b0;
      r_e_rd    <= '0;
      r_w_valid <= 1'b0;
      r_w_rd    <= '0;
      opcode    <= '0;
      funct3    <= '0;
      funct7    <= '0;
      opd1      <= '0;
      opd2      <= '0;
    end else begin
      // A flushed E instruction is dropped here instead of advancing to W.
      r_w_valid <= r_e_valid && !flush;
      r_w_rd    <= r_e_rd;
      r_e_valid <= w_accept;
      if (w_accept) begin
        r_e_rd <= in_rd;
        opcode <= in_opcode;
        funct3 <= in_funct3;
        funct7 <= in_funct7;
        opd1   <= w_rs1_val;
        opd2   <= w_rs2_used ? w_rs2_val : in_imm;
      end
    end
  end

  assign wb_valid = r_w_valid && (r_w_rd != 5'd0);
  assign wb_rd    = r_w_rd;
  assign wb_data  = alu_rslt;

  // Contents are deliberately not reset; x0 is never written and always reads as zero above.
  always_ff @(posedge clk) begin
    if (wb_valid) begin
      r_rf[r_w_rd] <= alu_rslt;
    end
  end

endmodule
